// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks:
//   - parity mode constants
//   - transmitter FSM state encoding
//   - baud divider and baud counter width helpers
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int calc_div(input int clk_freq, input int baud_rate);
        return (clk_freq + baud_rate / 2) / baud_rate;
    endfunction

    // Width of a down-counter that has to hold DIV-1.
    function automatic int baud_cnt_w(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a first-word-fall-through read port.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (flushes pointers)
//   wr_en, wr_data    write request and word; ignored when full
//   rd_en             pop the head word; ignored when empty
//   rd_data           current head word (valid whenever !empty)
//   full, empty       occupancy flags
//   count             current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    assign w_wr = wr_en && !full;
    assign w_rd = rd_en && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr && !w_rd)      r_count <= r_count + 1'b1;
            else if (w_rd && !w_wr) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// UART transmitter fed by a built-in FIFO. Words arrive on a valid/ready
// slave and leave LSB-first as start / data / optional parity / stop bits.
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset; flushes FIFO, aborts frame
//   axis_tdata   word to transmit
//   axis_tvalid  producer has a word
//   axis_tready  FIFO can accept a word (low while rst is high)
//   tx_data      registered serial line, idle high
//   tx_busy      a frame is on the line
//   fifo_count   FIFO occupancy
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          axis_tdata,
    input  logic                          axis_tvalid,
    output logic                          axis_tready,
    output logic                          tx_data,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int              DIV        = calc_div(CLK_FREQ, BAUD_RATE);
    localparam int              CNT_W      = baud_cnt_w(DIV);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIV - 1);
    // Parity codes outside odd/even behave as "none".
    localparam bit              PAR_EN     = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);

    if (DIV < 4) begin : g_bad_div
        $error("uart_tx_fifo: clock/baud ratio gives DIV < 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [DATA_BITS-1:0] w_fifo_rd;
    logic                 w_pop;

    tx_state_e            r_state,  w_state_n;
    logic [CNT_W-1:0]     r_cnt,    w_cnt_n;
    logic [3:0]           r_idx,    w_idx_n;
    logic                 r_tx,     w_tx_n;
    logic                 r_busy,   w_busy_n;
    logic [DATA_BITS-1:0] r_shift,  w_shift_n;
    logic                 r_par,    w_par_n;

    assign axis_tready = !rst && !w_fifo_full;
    assign tx_data     = r_tx;
    assign tx_busy     = r_busy;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (axis_tvalid && axis_tready),
        .wr_data (axis_tdata),
        .rd_en   (w_pop),
        .rd_data (w_fifo_rd),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_idx_n   = r_idx;
        w_tx_n    = r_tx;
        w_busy_n  = r_busy;
        w_shift_n = r_shift;
        w_par_n   = r_par;
        w_pop     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tx_n   = 1'b1;
                w_busy_n = 1'b0;
                w_pop    = !w_fifo_empty;
            end
            ST_START: begin
                if (r_cnt == '0) begin
                    w_state_n = ST_DATA;
                    w_cnt_n   = CNT_RELOAD;
                    w_idx_n   = '0;
                    w_tx_n    = r_shift[0];
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            ST_DATA: begin
                if (r_cnt == '0) begin
                    w_cnt_n = CNT_RELOAD;
                    if (r_idx == 4'(DATA_BITS - 1)) begin
                        w_idx_n = '0;
                        if (PAR_EN) begin
                            w_state_n = ST_PARITY;
                            w_tx_n    = r_par;
                        end else begin
                            w_state_n = ST_STOP;
                            w_tx_n    = 1'b1;
                        end
                    end else begin
                        // Next data bit is always shifted down into bit 0.
                        w_idx_n   = r_idx + 1'b1;
                        w_shift_n = r_shift >> 1;
                        w_tx_n    = r_shift[1];
                    end
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            ST_PARITY: begin
                if (r_cnt == '0) begin
                    w_state_n = ST_STOP;
                    w_cnt_n   = CNT_RELOAD;
                    w_idx_n   = '0;
                    w_tx_n    = 1'b1;
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            ST_STOP: begin
                if (r_cnt == '0) begin
                    if (r_idx == 4'(STOP_BITS - 1)) begin
                        // A queued word starts straight away: no idle gap.
                        w_pop     = !w_fifo_empty;
                        w_state_n = ST_IDLE;
                        w_busy_n  = 1'b0;
                    end else begin
                        w_idx_n = r_idx + 1'b1;
                        w_cnt_n = CNT_RELOAD;
                    end
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_tx_n    = 1'b1;
                w_busy_n  = 1'b0;
            end
        endcase

        // Loading a new frame overrides whatever the state chose above.
        if (w_pop) begin
            w_state_n = ST_START;
            w_cnt_n   = CNT_RELOAD;
            w_idx_n   = '0;
            w_tx_n    = 1'b0;
            w_busy_n  = 1'b1;
            w_shift_n = w_fifo_rd;
            w_par_n   = (^w_fifo_rd) ^ (PARITY == PAR_ODD);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_tx    <= w_tx_n;
            r_busy  <= w_busy_n;
        end
    end

    // Payload registers are only meaningful once a word is loaded.
    always_ff @(posedge clk) begin
        r_shift <= w_shift_n;
        r_par   <= w_par_n;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Five instances of uart_tx_fifo with different frame formats share one clock.
// Stimulus pushes the expected line pattern of each frame into a per-channel
// queue; one monitor per channel decodes the TX line and compares.
//   ch0: 8N1, DIV=217    ch1: 8N1, DIV=4 (burst, same-edge, reset)
//   ch2: 8E2, DIV=217    ch3: 8O1, DIV=4    ch4: 5N1, DIV=4
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    typedef struct {
        logic [15:0] bits;
        int          len;
        bit          b2b;
    } exp_t;

    localparam int DIVS [5] = '{217, 4, 217, 4, 4};
    localparam int NB   [5] = '{8, 8, 8, 8, 5};
    localparam int PB   [5] = '{0, 0, 1, 1, 0};
    localparam int NS   [5] = '{1, 1, 2, 1, 1};

    logic       clk = 1'b0;
    logic       rst_g;
    logic [4:0] r;
    logic [4:0] rsts;
    logic [4:0] tv;
    logic [8:0] td [5];
    logic [4:0] rdy, tx, busy;
    logic [4:0] cnt [5];

    int vec  = 0;
    int miss = 0;
    int cyc  = 0;
    bit chk_rdy  = 1'b0;
    bit saw_full = 1'b0;

    exp_t q0[$], q1[$], q2[$], q3[$], q4[$];

    assign rsts = {5{rst_g}} | r;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo #(.DATA_BITS(8)) u0 (
        .clk(clk), .rst(rsts[0]), .axis_tdata(td[0][7:0]), .axis_tvalid(tv[0]),
        .axis_tready(rdy[0]), .tx_data(tx[0]), .tx_busy(busy[0]), .fifo_count(cnt[0]));
    uart_tx_fifo #(.CLK_FREQ(400), .BAUD_RATE(100)) u1 (
        .clk(clk), .rst(rsts[1]), .axis_tdata(td[1][7:0]), .axis_tvalid(tv[1]),
        .axis_tready(rdy[1]), .tx_data(tx[1]), .tx_busy(busy[1]), .fifo_count(cnt[1]));
    uart_tx_fifo #(.PARITY(2), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rsts[2]), .axis_tdata(td[2][7:0]), .axis_tvalid(tv[2]),
        .axis_tready(rdy[2]), .tx_data(tx[2]), .tx_busy(busy[2]), .fifo_count(cnt[2]));
    uart_tx_fifo #(.CLK_FREQ(400), .BAUD_RATE(100), .PARITY(1)) u3 (
        .clk(clk), .rst(rsts[3]), .axis_tdata(td[3][7:0]), .axis_tvalid(tv[3]),
        .axis_tready(rdy[3]), .tx_data(tx[3]), .tx_busy(busy[3]), .fifo_count(cnt[3]));
    uart_tx_fifo #(.CLK_FREQ(400), .BAUD_RATE(100), .DATA_BITS(5)) u4 (
        .clk(clk), .rst(rsts[4]), .axis_tdata(td[4][4:0]), .axis_tvalid(tv[4]),
        .axis_tready(rdy[4]), .tx_data(tx[4]), .tx_busy(busy[4]), .fifo_count(cnt[4]));

    // ---------------- scoreboard queues ----------------
    function automatic void qpush(input int ch, input exp_t e);
        case (ch)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            3: q3.push_back(e);
            default: q4.push_back(e);
        endcase
    endfunction

    function automatic exp_t qpop(input int ch);
        case (ch)
            0: return q0.pop_front();
            1: return q1.pop_front();
            2: return q2.pop_front();
            3: return q3.pop_front();
            default: return q4.pop_front();
        endcase
    endfunction

    function automatic int qsize(input int ch);
        case (ch)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            3: return q3.size();
            default: return q4.size();
        endcase
    endfunction

    // 8N1 line pattern: start 0, data LSB first, stop 1.
    function automatic logic [15:0] frame8(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // ---------------- monitor: decode one channel's line ----------------
    task automatic monitor(input int ch);
        int          len;
        int          st;
        int          prev_end;
        logic [15:0] got;
        logic        v;
        bit          ok_w;
        bit          abort;
        exp_t        e;
        prev_end = -100;
        len = 1 + NB[ch] + PB[ch] + NS[ch];
        forever begin
            @(negedge clk);
            if (rsts[ch]) begin
                prev_end = -100;
                continue;
            end
            if (tx[ch] !== 1'b0) continue;
            st    = cyc;
            got   = '0;
            ok_w  = 1'b1;
            abort = 1'b0;
            v     = 1'b0;
            for (int b = 0; b < len && !abort; b++) begin
                for (int k = 0; k < DIVS[ch]; k++) begin
                    if (b != 0 || k != 0) @(negedge clk);
                    if (rsts[ch]) abort = 1'b1;
                    if (k == 0) v = tx[ch];
                    else if (tx[ch] !== v) ok_w = 1'b0;
                end
                got[b] = v;
            end
            if (abort) begin
                prev_end = -100;
                continue;
            end
            vec++;
            if (qsize(ch) == 0) begin
                miss++;
                $display("FAIL frame ch%0d: got unexpected frame %h, expected none", ch, got);
            end else begin
                e = qpop(ch);
                if (got !== e.bits || !ok_w || (e.b2b && st != prev_end + 1)) begin
                    miss++;
                    $display("FAIL frame ch%0d: got %h width_ok=%0d gap=%0d, expected %h width_ok=1 gap=%0d",
                             ch, got, ok_w, st - prev_end - 1, e.bits, e.b2b ? 0 : st - prev_end - 1);
                end
            end
            prev_end = cyc;
        end
    endtask

    for (genvar g = 0; g < 5; g++) begin : g_mon
        initial monitor(g);
    end

    // tready must track FIFO fullness every cycle while enabled.
    always @(negedge clk) begin
        if (chk_rdy) begin
            if (cnt[1] == 5'd16) saw_full = 1'b1;
            vec++;
            if (rdy[1] !== (cnt[1] != 5'd16)) begin
                miss++;
                $display("FAIL tready ch1: got %0b with count %0d, expected %0b",
                         rdy[1], cnt[1], cnt[1] != 5'd16);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Present a word and return #1 after the edge that accepts it; tvalid stays high.
    task automatic send(input int ch, input logic [8:0] d);
        int g;
        g = 0;
        td[ch] = d;
        tv[ch] = 1'b1;
        while (!rdy[ch] && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (!rdy[ch]) begin
            vec++;
            miss++;
            $display("FAIL send ch%0d: got tready stuck low, expected accept", ch);
            tv[ch] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic single(input int ch, input logic [8:0] d, input logic [15:0] bits,
                          input int len, input int exp_busy);
        int n;
        n = 0;
        qpush(ch, exp_t'{bits, len, 1'b0});
        @(negedge clk);
        send(ch, d);
        tv[ch] = 1'b0;
        check($sformatf("ch%0d line at accept edge", ch), tx[ch], 1);
        @(posedge clk);
        #1;
        check($sformatf("ch%0d start bit one edge later", ch), tx[ch], 0);
        check($sformatf("ch%0d busy at start", ch), busy[ch], 1);
        @(negedge clk);
        while (busy[ch] && n < 6000) begin
            n++;
            @(negedge clk);
        end
        check($sformatf("ch%0d busy cycles", ch), n, exp_busy);
    endtask

    task automatic drain(input int ch);
        int g;
        g = 0;
        while ((qsize(ch) != 0 || busy[ch]) && g < 8000) begin
            @(negedge clk);
            g++;
        end
        vec++;
        if (qsize(ch) != 0) begin
            miss++;
            $display("FAIL drain ch%0d: got %0d frames outstanding, expected 0", ch, qsize(ch));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n0;
        int g;
        rst_g = 1'b1;
        r     = '0;
        tv    = '0;
        for (int i = 0; i < 5; i++) td[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("reset ch%0d tx", i), tx[i], 1);
            check($sformatf("reset ch%0d busy", i), busy[i], 0);
            check($sformatf("reset ch%0d count", i), cnt[i], 0);
            check($sformatf("reset ch%0d tready", i), rdy[i], 0);
        end
        @(negedge clk);
        rst_g = 1'b0;
        #1;
        check("ch1 tready after reset", rdy[1], 1);

        // Hand-computed frames: 0x61 = 0110_0001
        single(0, 9'h061, 16'h02C2, 10, 2170);   // 8N1
        single(2, 9'h061, 16'h0EC2, 12, 2604);   // 8E2, parity 1
        single(3, 9'h061, 16'h04C2, 11, 44);     // 8O1, parity 0
        single(4, 9'h015, 16'h006A, 7, 28);      // 5N1, data 1,0,1,0,1

        // Burst of 20 with tvalid held high.
        @(negedge clk);
        chk_rdy  = 1'b1;
        saw_full = 1'b0;
        for (int i = 0; i < 20; i++) begin
            qpush(1, exp_t'{frame8(8'h40 + 8'(i)), 10, i != 0});
            send(1, {1'b0, 8'h40 + 8'(i)});
        end
        tv[1] = 1'b0;
        drain(1);
        chk_rdy = 1'b0;
        check("burst reached full", saw_full, 1);

        // Write and pop on the same edge with count = 3.
        @(negedge clk);
        n0 = 0;
        for (int i = 0; i < 4; i++) begin
            qpush(1, exp_t'{frame8(8'hA0 + 8'(i)), 10, i != 0});
            send(1, {1'b0, 8'hA0 + 8'(i)});
            if (i == 0) n0 = cyc;
        end
        tv[1] = 1'b0;
        check("count after 4 writes", cnt[1], 3);
        g = 0;
        while (cyc != n0 + 40 && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("count before same-edge op", cnt[1], 3);
        qpush(1, exp_t'{frame8(8'hA4), 10, 1'b1});
        td[1] = 9'h0A4;
        tv[1] = 1'b1;
        check("tready before same-edge op", rdy[1], 1);
        @(posedge clk);
        #1;
        tv[1] = 1'b0;
        check("count after same-edge op", cnt[1], 3);
        drain(1);

        // Reset mid-DATA with 5 words queued.
        @(negedge clk);
        n0 = 0;
        for (int i = 0; i < 6; i++) begin
            qpush(1, exp_t'{frame8(8'h11 * 8'(i + 1)), 10, i != 0});
            send(1, {1'b0, 8'h11 * 8'(i + 1)});
            if (i == 0) n0 = cyc;
        end
        tv[1] = 1'b0;
        check("count with 5 queued", cnt[1], 5);
        g = 0;
        while (cyc != n0 + 15 && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        #1;
        r[1] = 1'b1;
        q1.delete();
        #1;
        check("mid-frame reset tx", tx[1], 1);
        check("mid-frame reset count", cnt[1], 0);
        check("mid-frame reset tready", rdy[1], 0);
        check("mid-frame reset busy", busy[1], 0);
        repeat (3) @(posedge clk);
        #1;
        check("tready held low in reset", rdy[1], 0);
        @(negedge clk);
        r[1] = 1'b0;
        @(negedge clk);
        qpush(1, exp_t'{frame8(8'h5A), 10, 1'b0});
        send(1, 9'h05A);
        tv[1] = 1'b0;
        drain(1);

        for (int i = 0; i < 5; i++) drain(i);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter with a built-in transmit FIFO.
- Data bits, parity mode, stop-bit count and FIFO depth are all configurable.
- Accepts words on an AXI-Stream-style valid/ready slave and serialises them LSB-first onto a single TX line.
- Sits between on-board producers (switch-driven message generators, packet formatters) and the board's UART TX pin; allows bursts without per-byte stalls.

Parameters:
- CLK_FREQ, 25_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s. Divider DIV = (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE, rounded integer; DIV must be >= 4.
- DATA_BITS, 8: payload bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: legal values 1 or 2.
- FIFO_DEPTH, 16: FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- axis_tdata  in  DATA_BITS  word to transmit.
- axis_tvalid  in  1  producer has a word.
- axis_tready  out  1  FIFO can accept a word.
- tx_data  out  1  serial line, idle high.
- tx_busy  out  1  a frame is on the line.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - tx_data = 1, tx_busy = 0, fifo_count = 0.
  - FSM = IDLE; baud counter and bit index cleared.
  - axis_tready forced 0 while rst is high.
- Handshake:
  - axis_tready = !rst && (fifo_count != FIFO_DEPTH).
  - A word is written on any rising edge where axis_tvalid && axis_tready.
  - tdata must hold while tvalid is high and tready is low; tvalid may be deasserted at any time.
- FIFO:
  - Synchronous, first-word-fall-through read port.
  - Write when full is impossible (tready low). This holds even when a pop occurs on the same cycle: no same-cycle write-on-full.
  - Simultaneous write and pop with count in 1..DEPTH-1 leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO not empty, pop the head into the shift register, compute parity (XOR of the word; inverted for odd), go to START. tx_data = 0 and tx_busy = 1 from that edge.
  - Latency: a word accepted into an empty FIFO at edge N → start bit begins after edge N+1.
  - Every state holds its bit for exactly DIV cycles; the baud counter counts DIV-1 down to 0 and reloads on each bit transition.
  - START → DATA: DATA_BITS bits, LSB first.
  - DATA → PARITY if PARITY != 0, else → STOP.
  - PARITY → STOP. STOP drives 1 for STOP_BITS × DIV cycles.
  - STOP → IDLE; tx_busy falls on the same edge.
  - If the FIFO is non-empty at the end of STOP, the FSM pops directly and enters START (back-to-back frames, no idle gap). tx_busy stays 1.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) × DIV cycles, exact.
- tx_data is registered; no combinational path from any input to tx_data.
- Reset mid-frame: line returns high immediately, the FIFO is flushed, and the partial frame is lost.
- PARITY values 3 and above are treated as none. Illegal parameters are flagged by a generate-time error.

Decomposition:
- Package uart_pkg holds:
  - parity mode constants (PAR_NONE/ODD/EVEN);
  - FSM state encoding;
  - a constant function for DIV and the baud counter width.
- Sub-module sync_fifo (WIDTH, DEPTH): wr_en/wr_data/rd_en/rd_data/full/empty/count, async active-high reset. Reusable by a later uart_rx.

Test Plan:
- Default 8N1, 25 MHz / 115200 (DIV = 217), send 0x61:
  - line = 0,1,0,0,0,0,1,1,0,1, each 217 cycles;
  - tx_busy high for exactly 2170 cycles;
  - start bit begins 1 cycle after the accept edge.
- PARITY = 2, STOP_BITS = 2, send 0x61:
  - parity bit = 1, two stop bits;
  - frame = 2604 cycles.
- PARITY = 1 with 0x61 → parity bit 0; DATA_BITS = 5 with 0x15 → data bits 1,0,1,0,1.
- Burst of 20 words, tvalid held high, FIFO_DEPTH = 16:
  - tready drops when fifo_count = 16 and returns as soon as a pop frees an entry;
  - all 20 frames emitted in order, back-to-back, no idle cycles between stop and start.
- Assert rst for 3 cycles mid-DATA with 5 words queued:
  - tx_data = 1 and fifo_count = 0 immediately;
  - tready = 0 during reset;
  - the next accepted word produces a clean full frame.
- Write and pop on the same edge with count = 3: count stays 3, data order preserved.
